// File: rtl/arb_mux_2to1.sv
// Registered two-input round-robin arbiter with valid/ready handshakes.
// Merges streams A and B into one registered output; out_sel is 0 for A and 1 for B.
module arb_mux_2to1 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    input  logic             out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sel_q, sel_d;
    logic             last_sel_q, last_sel_d;

    logic             load_en;
    logic             grant_any;
    logic             grant_b;
    logic             accept;

    // Ties go to the source that did not win last; readies depend only on valids and out_ready.
    always_comb begin
        load_en   = (state_q == EMPTY) || out_ready;
        grant_any = a_valid || b_valid;
        grant_b   = b_valid && (!a_valid || !last_sel_q);
        a_ready   = load_en && grant_any && !grant_b && !rst;
        b_ready   = load_en && grant_b && !rst;
        accept    = a_ready || b_ready;
    end

    // State and payload registers; reset discards any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            data_q     <= '0;
            sel_q      <= 1'b0;
            last_sel_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            sel_q      <= sel_d;
            last_sel_q <= last_sel_d;
        end
    end

    // Next-state and payload capture.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        sel_d      = sel_q;
        last_sel_d = last_sel_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_ready && !accept) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (accept) begin
            data_d     = grant_b ? b_data : a_data;
            sel_d      = grant_b;
            last_sel_d = grant_b;
        end
    end

    // Output decode.
    always_comb begin
        out_valid = (state_q == FULL);
        out_data  = data_q;
        out_sel   = sel_q;
    end

endmodule

// File: tb/tb_arb_mux_2to1.sv
// Directed self-checking bench for arb_mux_2to1 with hand-computed expectations.
module tb_arb_mux_2to1;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, b_valid, out_ready;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready, out_valid, out_sel;
    logic [7:0] out_data;

    int vectors = 0;
    int miscompares = 0;

    arb_mux_2to1 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Upstream obligation: a pending word stays valid and stable until accepted.
    logic       a_pend, b_pend, rst_prev;
    logic [7:0] a_hold, b_hold;
    always @(posedge clk) begin
        if (!rst && !rst_prev && a_pend) begin
            vectors++;
            if (!(a_valid === 1'b1 && a_data === a_hold)) begin
                miscompares++;
                $display("FAIL a_obligation valid=%b data=%h exp_data=%h", a_valid, a_data, a_hold);
            end
        end
        if (!rst && !rst_prev && b_pend) begin
            vectors++;
            if (!(b_valid === 1'b1 && b_data === b_hold)) begin
                miscompares++;
                $display("FAIL b_obligation valid=%b data=%h exp_data=%h", b_valid, b_data, b_hold);
            end
        end
        a_pend   <= a_valid && !a_ready;
        b_pend   <= b_valid && !b_ready;
        a_hold   <= a_data;
        b_hold   <= b_data;
        rst_prev <= rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1;
        a_valid = 1'b1; a_data = 8'hA1;
        b_valid = 1'b1; b_data = 8'hB1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid out_valid=%b exp=0", out_valid); end
            vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_data out_data=%h exp=00", out_data); end
            vectors++; if (out_sel !== 1'b0) begin miscompares++; $display("FAIL reset_sel out_sel=%b exp=0", out_sel); end
            vectors++; if ({a_ready, b_ready} !== 2'b00) begin miscompares++; $display("FAIL reset_ready ready=%b exp=00", {a_ready, b_ready}); end
        end
        rst = 1'b0;
        settle();
        vectors++; if ({a_ready, b_ready} !== 2'b10) begin miscompares++; $display("FAIL reset_first_tie ready=%b exp=10", {a_ready, b_ready}); end
        tick();
        vectors++; if ({out_valid, out_sel, out_data} !== {1'b1, 1'b0, 8'hA1}) begin miscompares++; $display("FAIL reset_first_word v/s/d=%b/%b/%h exp=1/0/a1", out_valid, out_sel, out_data); end
        a_valid = 1'b0;
        tick();
        vectors++; if ({out_valid, out_sel, out_data} !== {1'b1, 1'b1, 8'hB1}) begin miscompares++; $display("FAIL reset_second_word v/s/d=%b/%b/%h exp=1/1/b1", out_valid, out_sel, out_data); end
        b_valid = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_drain out_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_single_source();
        logic [7:0] words [3];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        out_ready = 1'b1; b_valid = 1'b0; a_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_data = words[i];
            settle();
            vectors++; if ({a_ready, b_ready} !== 2'b10) begin miscompares++; $display("FAIL single_ready%0d ready=%b exp=10", i, {a_ready, b_ready}); end
            tick();
            vectors++; if ({out_valid, out_sel, out_data} !== {1'b1, 1'b0, words[i]}) begin miscompares++; $display("FAIL single_word%0d v/s/d=%b/%b/%h exp=1/0/%h", i, out_valid, out_sel, out_data, words[i]); end
        end
        a_valid = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain out_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_fairness();
        logic [7:0] ai, bi, exp_d;
        logic       exp_s;
        rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b1;
        ai = 8'h00; bi = 8'h00;
        a_valid = 1'b1; a_data = 8'hA0;
        b_valid = 1'b1; b_data = 8'hB0;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_s = (i % 2) == 1;
            exp_d = exp_s ? (8'hB0 + bi) : (8'hA0 + ai);
            vectors++; if ({out_valid, out_sel, out_data} !== {1'b1, exp_s, exp_d}) begin miscompares++; $display("FAIL fair_word%0d v/s/d=%b/%b/%h exp=1/%b/%h", i, out_valid, out_sel, out_data, exp_s, exp_d); end
            if (exp_s) begin bi = bi + 8'h01; b_data = 8'hB0 + bi; end
            else begin ai = ai + 8'h01; a_data = 8'hA0 + ai; end
        end
        tick();
        vectors++; if ({out_sel, out_data} !== {1'b0, 8'hA3}) begin miscompares++; $display("FAIL fair_word6 s/d=%b/%h exp=0/a3", out_sel, out_data); end
        a_valid = 1'b0;
        tick();
        vectors++; if ({out_sel, out_data} !== {1'b1, 8'hB3}) begin miscompares++; $display("FAIL fair_word7 s/d=%b/%h exp=1/b3", out_sel, out_data); end
        b_valid = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL fair_drain out_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1; a_valid = 1'b0;
        b_valid = 1'b1; b_data = 8'h5A;
        tick();
        vectors++; if ({out_valid, out_sel, out_data} !== {1'b1, 1'b1, 8'h5A}) begin miscompares++; $display("FAIL bp_load v/s/d=%b/%b/%h exp=1/1/5a", out_valid, out_sel, out_data); end
        out_ready = 1'b0;
        a_valid = 1'b1; a_data = 8'h3C;
        b_data = 8'h4D;
        for (int i = 0; i < 3; i++) begin
            settle();
            vectors++; if ({a_ready, b_ready} !== 2'b00) begin miscompares++; $display("FAIL bp_ready%0d ready=%b exp=00", i, {a_ready, b_ready}); end
            tick();
            vectors++; if ({out_valid, out_sel, out_data} !== {1'b1, 1'b1, 8'h5A}) begin miscompares++; $display("FAIL bp_hold%0d v/s/d=%b/%b/%h exp=1/1/5a", i, out_valid, out_sel, out_data); end
        end
        out_ready = 1'b1;
        settle();
        vectors++; if ({a_ready, b_ready} !== 2'b10) begin miscompares++; $display("FAIL bp_release ready=%b exp=10", {a_ready, b_ready}); end
        tick();
        vectors++; if ({out_valid, out_sel, out_data} !== {1'b1, 1'b0, 8'h3C}) begin miscompares++; $display("FAIL bp_next_a v/s/d=%b/%b/%h exp=1/0/3c", out_valid, out_sel, out_data); end
        a_valid = 1'b0;
        tick();
        vectors++; if ({out_valid, out_sel, out_data} !== {1'b1, 1'b1, 8'h4D}) begin miscompares++; $display("FAIL bp_next_b v/s/d=%b/%b/%h exp=1/1/4d", out_valid, out_sel, out_data); end
        b_valid = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain out_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        a_valid = 1'b1; a_data = 8'h77;
        tick();
        vectors++; if ({out_valid, out_sel, out_data} !== {1'b1, 1'b0, 8'h77}) begin miscompares++; $display("FAIL mr_load v/s/d=%b/%b/%h exp=1/0/77", out_valid, out_sel, out_data); end
        a_valid = 1'b0;
        b_valid = 1'b1; b_data = 8'h99;
        tick();
        vectors++; if ({out_valid, out_data} !== {1'b1, 8'h77}) begin miscompares++; $display("FAIL mr_stall v/d=%b/%h exp=1/77", out_valid, out_data); end
        rst = 1'b1; out_ready = 1'b1;
        a_valid = 1'b1; a_data = 8'h66;
        settle();
        vectors++; if ({a_ready, b_ready} !== 2'b00) begin miscompares++; $display("FAIL mr_ready ready=%b exp=00", {a_ready, b_ready}); end
        tick();
        vectors++; if ({out_valid, out_data} !== {1'b0, 8'h00}) begin miscompares++; $display("FAIL mr_discard v/d=%b/%h exp=0/00", out_valid, out_data); end
        rst = 1'b0;
        settle();
        vectors++; if ({a_ready, b_ready} !== 2'b10) begin miscompares++; $display("FAIL mr_tie ready=%b exp=10", {a_ready, b_ready}); end
        tick();
        vectors++; if ({out_valid, out_sel, out_data} !== {1'b1, 1'b0, 8'h66}) begin miscompares++; $display("FAIL mr_first v/s/d=%b/%b/%h exp=1/0/66", out_valid, out_sel, out_data); end
        a_valid = 1'b0;
        tick();
        vectors++; if ({out_valid, out_sel, out_data} !== {1'b1, 1'b1, 8'h99}) begin miscompares++; $display("FAIL mr_second v/s/d=%b/%b/%h exp=1/1/99", out_valid, out_sel, out_data); end
    endtask

    task automatic test_drain_load();
        out_ready = 1'b1; a_valid = 1'b0;
        b_valid = 1'b1; b_data = 8'hC3;
        settle();
        vectors++; if ({a_ready, b_ready} !== 2'b01) begin miscompares++; $display("FAIL dl_ready ready=%b exp=01", {a_ready, b_ready}); end
        tick();
        vectors++; if ({out_valid, out_sel, out_data} !== {1'b1, 1'b1, 8'hC3}) begin miscompares++; $display("FAIL dl_word v/s/d=%b/%b/%h exp=1/1/c3", out_valid, out_sel, out_data); end
        b_valid = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL dl_drain out_valid=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_fairness();
        test_backpressure();
        test_mid_reset();
        test_drain_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
